// File: rtl/uart_pkg.sv
// Shared UART defaults and helpers used by the transmitter, receiver and the
// button-driven transmit feeder.
package uart_pkg;

   localparam int DATA_W_DEF          = 8;
   localparam int FIFO_DEPTH_DEF      = 8;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   // Counter/pointer width that never collapses to zero bits.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // What the FIFO does in a given cycle.
   typedef struct packed {
      logic push;
      logic pop;
      logic drop;
   } fifo_op_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce for a bouncing push button.
// Produces the debounced level and a one-cycle pulse on each accepted 0->1 change.
module btn_debounce
   import uart_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic level,
   output logic rise
);

   localparam int            CW   = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level; any agreement restarts the qualification window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
         rise    <= 1'b0;
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= ~level;
            rise  <= ~level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Button-driven byte feeder: each debounced press captures the switch byte into
// a small FIFO that drains into the UART transmitter.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEF,
   parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          btn_in,
   input  logic                          tx_ready,
   output logic [DATA_W-1:0]             tx_data,
   output logic                          tx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty,
   output logic                          overflow
);

   localparam int            PW      = cnt_w(FIFO_DEPTH);
   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic              btn_level;
   logic              btn_rise;
   logic              push;
   fifo_op_t          op;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in),
      .level  (btn_level),
      .rise   (btn_rise)
   );

   // A rise pulse always coincides with the new high level.
   assign push = btn_rise & btn_level;

   // tx_valid/tx_ready: a byte transfers on every rising edge where both are
   // high; while tx_valid is high and tx_ready low, tx_data holds its value.
   assign tx_valid = (count != '0);
   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign tx_data  = mem[rd_ptr];

   // A push into a full FIFO still fits when a pop frees the head slot.
   always_comb begin
      op      = '0;
      op.pop  = tx_valid & tx_ready;
      op.push = push & (~full | op.pop);
      op.drop = push & full & ~op.pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= op.drop;
         if (op.push) wr_ptr <= wr_ptr + 1'b1;
         if (op.pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({op.push, op.pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; an empty FIFO never exposes its contents.
   always_ff @(posedge clk) begin
      if (op.push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model with a
// per-cycle compare process, directed scenarios and randomized presses.
module tb_uart_tx_feeder;

   localparam int W     = 8;
   localparam int DEPTH = 8;
   localparam int DEB   = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         btn_in = 1'b0;
   logic         tx_ready = 1'b0;
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic [3:0]   count;
   logic         full;
   logic         empty;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_feeder #(
      .DATA_W          (W),
      .FIFO_DEPTH      (DEPTH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .btn_in   (btn_in),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the button seen two cycles late must disagree with the
   // accepted level for DEB consecutive cycles to flip it; a flip to 1 pushes
   // data_in on the following cycle.
   logic [W-1:0] m_q [$];
   logic         m_ovf = 1'b0;
   logic         m_rise = 1'b0;
   logic         m_level = 1'b0;
   int           m_run = 0;
   logic [1:0]   m_dly = 2'b00;
   bit           m_was_full;
   bit           m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ovf   = 1'b0;
         m_rise  = 1'b0;
         m_level = 1'b0;
         m_run   = 0;
         m_dly   = 2'b00;
      end else begin
         m_was_full = (m_q.size() == DEPTH);
         m_pop      = (m_q.size() != 0) && tx_ready;
         if (m_pop) void'(m_q.pop_front());
         m_ovf = 1'b0;
         if (m_rise) begin
            if (m_was_full && !m_pop) m_ovf = 1'b1;
            else m_q.push_back(data_in);
         end
         m_rise = 1'b0;
         if (m_dly[1] != m_level) begin
            m_run++;
            if (m_run == DEB) begin
               m_level = ~m_level;
               m_run   = 0;
               m_rise  = m_level;
            end
         end else begin
            m_run = 0;
         end
         m_dly = {m_dly[0], btn_in};
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_data = '0;
   int           ovf_seen = 0;
   logic [W-1:0] pop_log [$];

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         chk("count", 32'(count), 32'(m_q.size()));
         chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
         chk("empty", 32'(empty), 32'(m_q.size() == 0));
         chk("full", 32'(full), 32'(m_q.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
         if (prev_hold && tx_valid) chk("tx_data_hold", 32'(tx_data), 32'(prev_data));
         prev_hold = tx_valid && !tx_ready;
         prev_data = tx_data;
         if (overflow) ovf_seen++;
         if (tx_valid && tx_ready) pop_log.push_back(tx_data);
      end
   end

   bit rand_ready = 1'b0;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic press(input logic [W-1:0] d, input int hi, input int lo);
      data_in = d;
      btn_in  = 1'b1;
      step(hi);
      btn_in  = 1'b0;
      step(lo);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   int lat;
   int lat_at;
   bit got;

   initial begin
      // Reset state
      rst_n = 1'b0;
      step(3);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      step(2);

      // Clean press: latency window and captured byte
      data_in = 8'hC9;
      btn_in  = 1'b1;
      got     = 1'b0;
      lat     = 0;
      lat_at  = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         lat++;
         if (tx_valid && !got) begin
            got    = 1'b1;
            lat_at = lat;
         end
      end
      chk("t1_valid_seen", 32'(got), 32'd1);
      chk("t1_latency_in_window", 32'(lat_at >= DEB + 2 && lat_at <= DEB + 5), 32'd1);
      chk("t1_tx_data", 32'(tx_data), 32'hC9);
      chk("t1_count", 32'(count), 32'd1);
      btn_in = 1'b0;
      step(25);
      tx_ready = 1'b1;
      step(3);
      tx_ready = 1'b0;

      // Bouncing input never settles long enough
      for (int i = 0; i < 20; i++) begin
         btn_in = ~btn_in;
         step(3);
      end
      btn_in = 1'b0;
      step(30);
      chk("t2_count", 32'(count), 32'd0);
      chk("t2_valid", 32'(tx_valid), 32'd0);

      // Fill to full, one dropped press, then ordered drain
      tx_ready = 1'b0;
      ovf_seen = 0;
      for (int i = 1; i <= 9; i++) begin
         press(W'(i), 25, 25);
         if (i == 8) chk("t3_full_after_8", 32'(full), 32'd1);
      end
      chk("t3_overflow_once", 32'(ovf_seen), 32'd1);
      chk("t3_count", 32'(count), 32'd8);
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("t3_drain_valid", 32'(tx_valid), 32'd1);
         chk("t3_drain_order", 32'(tx_data), 32'(i));
         step(1);
      end
      chk("t3_empty", 32'(empty), 32'd1);

      // Push into a full FIFO in the same cycle as a pop
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) press(8'h30 + W'(i), 25, 25);
      chk("t4_count_full", 32'(count), 32'd8);
      data_in = 8'hAA;
      btn_in  = 1'b1;
      for (int i = 0; i < 40 && !m_rise; i++) step(1);
      chk("t4_push_pending", 32'(m_rise), 32'd1);
      tx_ready = 1'b1;
      pop_log.delete();
      ovf_seen = 0;
      step(1);
      chk("t4_count_stays_full", 32'(count), 32'd8);
      chk("t4_no_overflow", 32'(overflow), 32'd0);
      step(12);
      btn_in = 1'b0;
      step(25);
      chk("t4_pop_total", 32'(pop_log.size()), 32'd9);
      if (pop_log.size() == 9) begin
         chk("t4_first_pop", 32'(pop_log[0]), 32'h30);
         chk("t4_aa_eighth_after_push", 32'(pop_log[8]), 32'hAA);
      end
      chk("t4_overflow_count", 32'(ovf_seen), 32'd0);

      // Pointer wrap: 5 in, 5 out, then 6 more
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) press(8'h50 + W'(i), 25, 25);
      tx_ready = 1'b1;
      step(8);
      tx_ready = 1'b0;
      chk("t5_empty_mid", 32'(empty), 32'd1);
      for (int i = 0; i < 6; i++) press(8'h10 + W'(i), 25, 25);
      chk("t5_count", 32'(count), 32'd6);
      pop_log.delete();
      tx_ready = 1'b1;
      step(10);
      chk("t5_pop_total", 32'(pop_log.size()), 32'd6);
      if (pop_log.size() == 6)
         for (int i = 0; i < 6; i++) chk("t5_order", 32'(pop_log[i]), 32'h10 + 32'(i));

      // Asynchronous reset mid-drain, button held through release
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) press(8'h60 + W'(i), 25, 25);
      tx_ready = 1'b1;
      for (int i = 0; i < 10 && m_q.size() != 4; i++) step(1);
      chk("t6_count_before", 32'(count), 32'd4);
      tx_ready = 1'b0;
      data_in  = 8'h77;
      btn_in   = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_valid", 32'(tx_valid), 32'd0);
      chk("t6_async_empty", 32'(empty), 32'd1);
      #2;
      rst_n = 1'b1;
      step(30);
      chk("t6_new_count", 32'(count), 32'd1);
      chk("t6_new_data", 32'(tx_data), 32'h77);
      btn_in = 1'b0;
      step(25);
      tx_ready = 1'b1;
      step(3);

      // Randomized presses with glitches and random transmitter readiness
      for (int it = 0; it < 30; it++) begin
         rand_ready = 1'($urandom_range(0, 1));
         if (!rand_ready) tx_ready = 1'($urandom_range(0, 1));
         for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
            btn_in = 1'b1;
            step($urandom_range(1, DEB - 4));
            btn_in = 1'b0;
            step($urandom_range(1, 6));
         end
         press(W'($urandom), $urandom_range(DEB + 5, DEB + 15), $urandom_range(DEB + 5, DEB + 15));
      end
      rand_ready = 1'b0;
      tx_ready   = 1'b1;
      step(12);
      chk("final_empty", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
